mem_port_arbiter: RTL and testbench

Shares the single unified memory port between instruction fetch and the execute stage's data port (loads, stores, and the second half of misaligned accesses). The arbiter uses fixed priority with data first and a starvation guard for fetch. It tracks pipelined reads in flight and routes each response back to its owner exactly `LAT` cycles after the grant. It sits between fetch/execute and the memory model/BRAM wrapper, and it drops fetch responses made stale by a taken branch or an exception.

---
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one pipelined memory port between instruction fetch
// and the data port. Data has fixed priority over fetch. A starvation counter
// forces one fetch grant after STARVE_MAX consecutive denied cycles. Reads are
// tracked by a LAT-deep tag pipeline so that each response is routed to the
// requester that issued it.
// Ports:
//   clk, rst                            clock, synchronous active-high reset
//   if_req/if_addr/if_gnt               fetch request, address, combinational grant
//   if_rvalid/if_rdata                  fetch response
//   flush                               kills in-flight fetch reads, blocks fetch grant
//   d_req/d_addr/d_we/d_wdata/d_gnt     data request (d_we == 0 is a read), grant
//   d_rvalid/d_rdata                    data response
//   mem_req/mem_addr/mem_we/mem_wdata   access issued to memory
//   mem_rdata                           memory read data, valid LAT cycles after issue
module mem_port_arbiter #(
   parameter int unsigned LAT        = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        flush,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [3:0]  d_we,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

   logic [SW-1:0]  starve_cnt;
   logic [LAT-1:0] tag_valid;
   logic [LAT-1:0] tag_owner;   // 0 = fetch, 1 = data
   logic [LAT-1:0] tag_keep;
   logic           fetch_ok;
   logic           push_valid;

   // Arbitration and request mux; reset suppresses every grant.
   always_comb begin
      fetch_ok  = if_req && !flush && !rst;
      if_gnt    = fetch_ok && (!d_req || (starve_cnt == STARVE_LIMIT));
      d_gnt     = d_req && !rst && !if_gnt;
      mem_req   = if_gnt || d_gnt;
      mem_addr  = 32'h0;
      mem_we    = 4'h0;
      mem_wdata = 32'h0;
      if (if_gnt) begin
         mem_addr = if_addr;
      end else if (d_gnt) begin
         mem_addr  = d_addr;
         mem_we    = d_we;
         mem_wdata = d_wdata;
      end
      push_valid = mem_req && (mem_we == 4'h0);
   end

   // Flush invalidates every fetch-owned tag, including the one at the output.
   always_comb begin
      tag_keep = flush ? (tag_valid & tag_owner) : tag_valid;
   end

   // Response routing from the oldest tag.
   always_comb begin
      if_rvalid = tag_keep[LAT-1] && !tag_owner[LAT-1] && !rst;
      d_rvalid  = tag_keep[LAT-1] &&  tag_owner[LAT-1] && !rst;
      if_rdata  = mem_rdata;
      d_rdata   = mem_rdata;
   end

   // In-flight tag pipeline: stage 0 holds the access issued last cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_valid <= '0;
         tag_owner <= '0;
      end else begin
         tag_valid[0] <= push_valid;
         tag_owner[0] <= d_gnt;
         for (int i = 1; i < int'(LAT); i++) begin
            tag_valid[i] <= tag_keep[i-1];
            tag_owner[i] <= tag_owner[i-1];
         end
      end
   end

   // Starvation counter: counts consecutive cycles fetch was eligible but denied.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (fetch_ok && !if_gnt) begin
         if (starve_cnt != STARVE_LIMIT) begin
            starve_cnt <= starve_cnt + SW'(1);
         end
      end else begin
         starve_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors with hand-computed expectations for
// mem_port_arbiter at LAT=2, STARVE_MAX=4.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        flush;
   logic        d_req;
   logic [31:0] d_addr;
   logic [3:0]  d_we;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [3:0]  mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   mem_port_arbiter #(.LAT(2), .STARVE_MAX(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .flush     (flush),
      .d_req     (d_req),
      .d_addr    (d_addr),
      .d_we      (d_we),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to the next cycle: inputs change 1 time unit after the edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; if_req = 1'b0; if_addr = 32'h0; flush = 1'b0;
      d_req = 1'b0; d_addr = 32'h0; d_we = 4'h0; d_wdata = 32'h0;
      mem_rdata = 32'h0;
   endtask

   // Let combinational outputs settle before sampling.
   task automatic settle();
      #2;
   endtask

   initial begin
      idle();
      // Reset: grants suppressed even with requests present.
      rst = 1'b1; if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_addr = 32'h80;
      next_cycle();
      settle();
      chk("rst_if_gnt",    32'(if_gnt),    32'h0);
      chk("rst_d_gnt",     32'(d_gnt),     32'h0);
      chk("rst_mem_req",   32'(mem_req),   32'h0);
      chk("rst_mem_addr",  mem_addr,       32'h0);
      chk("rst_if_rvalid", 32'(if_rvalid), 32'h0);
      chk("rst_d_rvalid",  32'(d_rvalid),  32'h0);
      next_cycle();
      idle();

      // Single fetch, returns LAT=2 cycles later; fetch grant zeroes we/wdata.
      next_cycle();
      if_req = 1'b1; if_addr = 32'h100; d_wdata = 32'h5555AAAA; d_we = 4'hF;
      settle();
      chk("f1_if_gnt",    32'(if_gnt), 32'h1);
      chk("f1_d_gnt",     32'(d_gnt),  32'h0);
      chk("f1_mem_addr",  mem_addr,    32'h100);
      chk("f1_mem_we",    32'(mem_we), 32'h0);
      chk("f1_mem_wdata", mem_wdata,   32'h0);
      next_cycle(); idle();
      settle();
      chk("f1_idle_mem_req",  32'(mem_req),   32'h0);
      chk("f1_idle_mem_addr", mem_addr,       32'h0);
      chk("f1_rv_early",      32'(if_rvalid), 32'h0);
      next_cycle(); mem_rdata = 32'hDEAD0001;
      settle();
      chk("f1_if_rvalid", 32'(if_rvalid), 32'h1);
      chk("f1_if_rdata",  if_rdata,       32'hDEAD0001);
      chk("f1_d_rvalid",  32'(d_rvalid),  32'h0);
      next_cycle(); idle();
      settle();
      chk("f1_rv_once", 32'(if_rvalid), 32'h0);

      // Data beats fetch, fetch goes next cycle; responses routed to owners.
      next_cycle();
      d_req = 1'b1; d_addr = 32'h2000; if_req = 1'b1; if_addr = 32'h104;
      settle();
      chk("c_d_gnt",    32'(d_gnt),  32'h1);
      chk("c_if_gnt",   32'(if_gnt), 32'h0);
      chk("c_mem_addr", mem_addr,    32'h2000);
      next_cycle(); d_req = 1'b0;
      settle();
      chk("c_if_gnt2",   32'(if_gnt), 32'h1);
      chk("c_mem_addr2", mem_addr,    32'h104);
      next_cycle(); idle(); mem_rdata = 32'h11112222;
      settle();
      chk("c_d_rvalid",  32'(d_rvalid),  32'h1);
      chk("c_d_rdata",   d_rdata,        32'h11112222);
      chk("c_if_rv_no",  32'(if_rvalid), 32'h0);
      next_cycle(); mem_rdata = 32'h33334444;
      settle();
      chk("c_if_rvalid", 32'(if_rvalid), 32'h1);
      chk("c_if_rdata",  if_rdata,       32'h33334444);
      chk("c_d_rv_no",   32'(d_rvalid),  32'h0);

      // Starvation: fetch forced through on the 5th contended cycle only.
      for (int c = 0; c < 7; c++) begin
         next_cycle(); idle();
         d_req = 1'b1; d_addr = 32'h3000; if_req = 1'b1; if_addr = 32'h108;
         settle();
         chk($sformatf("stv_if_gnt_%0d", c), 32'(if_gnt), (c == 4) ? 32'h1 : 32'h0);
         chk($sformatf("stv_d_gnt_%0d", c),  32'(d_gnt),  (c == 4) ? 32'h0 : 32'h1);
      end
      for (int c = 0; c < 3; c++) begin
         next_cycle(); idle();
      end

      // Flush drops both in-flight fetches; data read issued during flush survives.
      next_cycle(); if_req = 1'b1; if_addr = 32'h200;
      settle();
      chk("fl_gnt0", 32'(if_gnt), 32'h1);
      next_cycle(); if_addr = 32'h204;
      settle();
      chk("fl_gnt1", 32'(if_gnt), 32'h1);
      next_cycle(); if_addr = 32'h208; flush = 1'b1; d_req = 1'b1; d_addr = 32'h2100;
      mem_rdata = 32'hBAD00000;
      settle();
      chk("fl_if_gnt",   32'(if_gnt),    32'h0);
      chk("fl_d_gnt",    32'(d_gnt),     32'h1);
      chk("fl_if_rv_c2", 32'(if_rvalid), 32'h0);
      next_cycle(); idle(); mem_rdata = 32'hBAD00001;
      settle();
      chk("fl_if_rv_c3", 32'(if_rvalid), 32'h0);
      chk("fl_d_rv_c3",  32'(d_rvalid),  32'h0);
      next_cycle(); mem_rdata = 32'h77778888;
      settle();
      chk("fl_d_rvalid", 32'(d_rvalid),  32'h1);
      chk("fl_d_rdata",  d_rdata,        32'h77778888);
      chk("fl_if_rv_c4", 32'(if_rvalid), 32'h0);

      // Store produces no response; following read returns normally.
      next_cycle(); idle();
      d_req = 1'b1; d_addr = 32'h2002; d_we = 4'b1100; d_wdata = 32'hABCD0000;
      settle();
      chk("st_d_gnt",     32'(d_gnt),  32'h1);
      chk("st_mem_addr",  mem_addr,    32'h2002);
      chk("st_mem_we",    32'(mem_we), 32'hC);
      chk("st_mem_wdata", mem_wdata,   32'hABCD0000);
      next_cycle(); d_addr = 32'h2004; d_we = 4'h0; d_wdata = 32'h0;
      settle();
      chk("st_rd_gnt", 32'(d_gnt),  32'h1);
      chk("st_rd_we",  32'(mem_we), 32'h0);
      next_cycle(); idle();
      settle();
      chk("st_no_rv", 32'(d_rvalid), 32'h0);
      next_cycle(); mem_rdata = 32'h9999AAAA;
      settle();
      chk("st_rd_rvalid", 32'(d_rvalid), 32'h1);
      chk("st_rd_rdata",  d_rdata,       32'h9999AAAA);

      // Reset kills in-flight read; new fetch after reset returns normally.
      next_cycle(); idle(); if_req = 1'b1; if_addr = 32'h300;
      settle();
      chk("r_gnt0", 32'(if_gnt), 32'h1);
      next_cycle(); rst = 1'b1; if_addr = 32'h304;
      settle();
      chk("r_gnt_in_rst", 32'(if_gnt),  32'h0);
      chk("r_memreq_rst", 32'(mem_req), 32'h0);
      next_cycle(); idle();
      settle();
      chk("r_no_rv_c2", 32'(if_rvalid), 32'h0);
      next_cycle(); if_req = 1'b1; if_addr = 32'h308;
      settle();
      chk("r_gnt3",     32'(if_gnt),    32'h1);
      chk("r_no_rv_c3", 32'(if_rvalid), 32'h0);
      next_cycle(); idle();
      next_cycle(); mem_rdata = 32'hCAFE0308;
      settle();
      chk("r_rv_c5",    32'(if_rvalid), 32'h1);
      chk("r_rdata_c5", if_rdata,       32'hCAFE0308);

      // Reset clears a partially built starvation count.
      for (int c = 0; c < 3; c++) begin
         next_cycle(); idle();
         d_req = 1'b1; d_addr = 32'h4000; if_req = 1'b1; if_addr = 32'h400;
      end
      next_cycle(); rst = 1'b1;
      for (int c = 0; c < 5; c++) begin
         next_cycle(); idle();
         d_req = 1'b1; d_addr = 32'h4000; if_req = 1'b1; if_addr = 32'h400;
         settle();
         chk($sformatf("rs_if_gnt_%0d", c), 32'(if_gnt), (c == 4) ? 32'h1 : 32'h0);
      end
      next_cycle(); idle();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
